// File: rtl/hazard_lane.sv
// rtl/hazard_lane.sv - parametrised traffic lane: stepping obstacle row with sticky collision flag
module hazard_lane #(
  parameter int WIDTH    = 16,
  parameter int SPEED_W  = 8,
  parameter int PRESCALE = 50000,
  parameter int WRAP     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   init,
  input  logic               dir,
  input  logic [SPEED_W-1:0] speed,
  input  logic               fill_in,
  input  logic [WIDTH-1:0]   frog_row,
  output logic [WIDTH-1:0]   row_out,
  output logic               step,
  output logic               lose
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]    ps_cnt;
  logic [SPEED_W-1:0] step_cnt;
  // Set by load; keeps a freshly reset lane (no pattern loaded yet) from stepping.
  logic               armed;
  logic               tick;
  logic               hit;
  logic               shift_due;
  logic               in_left;
  logic               in_right;
  logic [WIDTH-1:0]   shifted;

  // Tick, collision and the candidate shifted row, all from current registers.
  // The period minus one, 2^SPEED_W - speed - 1, is simply ~speed, so it fits in SPEED_W bits.
  always_comb begin
    tick      = (ps_cnt == PS_W'(PRESCALE - 1));
    hit       = |(frog_row & row_out);
    shift_due = tick && armed && (speed != '0) && (step_cnt >= ~speed);
    in_left   = (WRAP != 0) ? row_out[WIDTH-1] : fill_in;
    in_right  = (WRAP != 0) ? row_out[0]       : fill_in;
    if (dir) begin
      shifted = {in_right, row_out[WIDTH-1:1]};
    end else begin
      shifted = {row_out[WIDTH-2:0], in_left};
    end
  end

  // Lane state: prescaler, step counter, obstacle row, step pulse and sticky lose; load overrides all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt   <= '0;
      step_cnt <= '0;
      armed    <= 1'b0;
      row_out  <= '0;
      step     <= 1'b0;
      lose     <= 1'b0;
    end else if (load) begin
      ps_cnt   <= '0;
      step_cnt <= '0;
      armed    <= 1'b1;
      row_out  <= init;
      step     <= 1'b0;
      lose     <= 1'b0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      lose   <= lose | hit;
      step   <= 1'b0;
      if (shift_due) begin
        row_out  <= shifted;
        step_cnt <= '0;
        step     <= 1'b1;
      end else if (tick && armed && (speed != '0)) begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule
